// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin owner of the single-port command RAM, shared
// between single-word host commands and fixed-length AES block bursts.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | no transaction; arbitrate between h_req and a_req
// S_HOST_ACC  | host RAM access cycle (read or write)
// S_HOST_WAIT | host read: RAM output is captured into h_rdata
// S_AES_ACC   | BURST back-to-back AES accesses at base+idx
// S_AES_DRAIN | AES read: last RAM word still in flight
module ram_port_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int BURST  = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_ack,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [IDX_W-1:0]  a_idx,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOST_ACC,
    S_HOST_WAIT,
    S_AES_ACC,
    S_AES_DRAIN
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_host;
  logic                r_we;
  logic [IDX_W-1:0]    r_idx;
  logic                r_ram_en;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_din;
  logic                r_h_ack;
  logic [DATA_W-1:0]   r_h_rdata;
  logic                r_a_done;
  logic                r_a_rvalid;
  logic [DATA_W-1:0]   r_a_rdata;
  logic                r_rd_pend;

  logic                w_grant_h;
  logic                w_grant_a;
  logic                w_aes_last;
  logic                w_nxt_acc;
  logic                w_we_nxt;
  logic                w_aes_wr;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Arbitration and next-state decode. Completion pulses coincide with the
  // first IDLE cycle; arbitration holds off for that cycle so the finished
  // requester can drop its level request and the other side takes the slot.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_h   = 1'b0;
    w_grant_a   = 1'b0;
    w_aes_last  = (r_state == S_AES_ACC) && (r_idx == IDX_W'(BURST - 1));
    case (r_state)
      S_IDLE: begin
        if (!r_h_ack && !r_a_done) begin
          if (h_req && a_req) begin
            w_grant_h = !r_last_host;
            w_grant_a = r_last_host;
          end else begin
            w_grant_h = h_req;
            w_grant_a = a_req;
          end
          if (w_grant_h)      w_state_nxt = S_HOST_ACC;
          else if (w_grant_a) w_state_nxt = S_AES_ACC;
        end
      end
      S_HOST_ACC:  w_state_nxt = r_we ? S_IDLE : S_HOST_WAIT;
      S_HOST_WAIT: w_state_nxt = S_IDLE;
      S_AES_ACC: begin
        if (w_aes_last) w_state_nxt = r_we ? S_IDLE : S_AES_DRAIN;
      end
      S_AES_DRAIN: w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  assign w_nxt_acc = (w_state_nxt == S_HOST_ACC) || (w_state_nxt == S_AES_ACC);
  assign w_we_nxt  = w_grant_h ? h_we : (w_grant_a ? a_we : r_we);
  assign w_aes_wr  = (r_state == S_AES_ACC) && r_we;

  // Command latch and registered RAM control, computed from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_host <= 1'b0;
      r_we        <= 1'b0;
      r_idx       <= '0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
    end else begin
      r_we     <= w_we_nxt;
      r_ram_en <= w_nxt_acc;
      r_ram_we <= w_nxt_acc && w_we_nxt;
      if (w_grant_h) begin
        r_last_host <= 1'b1;
        r_ram_addr  <= h_addr;
        r_ram_din   <= h_wdata;
      end else if (w_grant_a) begin
        r_last_host <= 1'b0;
        r_ram_addr  <= a_base;
      end else if (r_state == S_AES_ACC) begin
        r_ram_addr <= r_ram_addr + ADDR_W'(1);
      end
      if ((r_state == S_AES_ACC) && !w_aes_last) r_idx <= r_idx + IDX_W'(1);
      else                                       r_idx <= '0;
    end
  end

  // Completion pulses and read-data return paths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_ack    <= 1'b0;
      r_h_rdata  <= '0;
      r_a_done   <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_rd_pend  <= 1'b0;
    end else begin
      r_h_ack    <= ((r_state == S_HOST_ACC) && r_we) || (r_state == S_HOST_WAIT);
      r_a_done   <= (w_aes_last && r_we) || (r_state == S_AES_DRAIN);
      r_rd_pend  <= (r_state == S_AES_ACC) && !r_we;
      r_a_rvalid <= r_rd_pend;
      if (r_state == S_HOST_WAIT) r_h_rdata <= ram_dout;
      if (r_rd_pend)              r_a_rdata <= ram_dout;
    end
  end

  // AES write data comes straight from the requester for the current index.
  assign ram_din  = w_aes_wr ? a_wdata : r_ram_din;
  assign ram_en   = r_ram_en;
  assign ram_we   = r_ram_we;
  assign ram_addr = r_ram_addr;
  assign a_idx    = r_idx;
  assign h_ack    = r_h_ack;
  assign h_rdata  = r_h_rdata;
  assign a_done   = r_a_done;
  assign a_rvalid = r_a_rvalid;
  assign a_rdata  = r_a_rdata;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed test-plan cases plus randomized single,
// simultaneous and staggered transactions against a transaction-level model.
module tb_ram_port_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int BURST  = 4;
  localparam int IDX_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              h_req, h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_ack;
  logic [DATA_W-1:0] h_rdata;
  logic              a_req, a_we;
  logic [ADDR_W-1:0] a_base;
  logic [DATA_W-1:0] a_wdata;
  logic [IDX_W-1:0]  a_idx;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic              a_done;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;
  logic              busy;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_rdata(h_rdata),
    .a_req(a_req), .a_we(a_we), .a_base(a_base), .a_wdata(a_wdata),
    .a_idx(a_idx), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_done(a_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy)
  );

  // Synchronous single-port RAM with a preload port used during reset.
  logic [DATA_W-1:0] mem [128];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  logic [DATA_W-1:0] aes_wbuf [BURST];
  assign a_wdata = aes_wbuf[a_idx];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory contents, expected access stream, round-robin memory.
  typedef struct packed {
    logic                        aes;
    logic                        we;
    logic [ADDR_W-1:0]           addr;
    logic [BURST-1:0][DATA_W-1:0] wd;
    logic [BURST-1:0][DATA_W-1:0] rd;
  } txn_t;

  typedef logic [1+ADDR_W+DATA_W-1:0] acc_t;
  acc_t              obs_q[$];
  acc_t              exp_q[$];
  logic [DATA_W-1:0] ref_mem [128];
  bit                exp_last_aes = 1'b1;
  logic [DATA_W-1:0] exp_hrdata = '0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("we_without_en", 64'(ram_we & ~ram_en), 64'd0);
      if (ram_en) obs_q.push_back({ram_we, ram_addr, ram_we ? ram_din : 32'd0});
    end
  end

  function automatic int lat_of(input txn_t t);
    if (t.aes) return t.we ? BURST + 1 : BURST + 2;
    return t.we ? 2 : 3;
  endfunction

  task automatic model_apply(inout txn_t t);
    int n;
    logic [ADDR_W-1:0] a;
    n = t.aes ? BURST : 1;
    for (int i = 0; i < n; i++) begin
      a = t.addr + ADDR_W'(i);
      exp_q.push_back({t.we, a, t.we ? t.wd[i] : 32'd0});
      if (t.we) ref_mem[a] = t.wd[i];
      else      t.rd[i] = ref_mem[a];
    end
    exp_last_aes = t.aes;
  endtask

  function automatic txn_t rand_txn(input bit aes);
    txn_t t;
    t = '0;
    t.aes = aes;
    t.we  = 1'($urandom_range(0, 1));
    t.addr = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 7))
                                         : ADDR_W'($urandom_range(120, 127));
    for (int i = 0; i < BURST; i++) t.wd[i] = $urandom;
    return t;
  endfunction

  task automatic check_acc();
    chk("acc_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk("ram_access", 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero();
    chk("rst_ctrl", 64'({h_ack, a_rvalid, a_done, ram_en, ram_we, busy, a_idx, ram_addr}), 64'd0);
    chk("rst_h_rdata", 64'(h_rdata), 64'd0);
    chk("rst_a_rdata", 64'(a_rdata), 64'd0);
    chk("rst_ram_din", 64'(ram_din), 64'd0);
  endtask

  // Called and returns at #1 after a rising edge; that cycle is cycle 0.
  task automatic run_host(input txn_t t, input int exp_lat, input bit hold);
    bit seen;
    seen = 1'b0;
    h_req = 1'b1; h_we = t.we; h_addr = t.addr; h_wdata = t.wd[0];
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      if (h_ack) begin
        seen = 1'b1;
        chk("host_latency", 64'(k), 64'(exp_lat));
        chk("host_busy_at_ack", 64'(busy), 64'd0);
        if (!t.we) exp_hrdata = t.rd[0];
        chk("host_rdata", 64'(h_rdata), 64'(exp_hrdata));
      end
    end
    if (!seen) chk("host_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    if (!hold) begin
      h_req = 1'b0;
      @(negedge clk);
      chk("host_ack_pulse", 64'(h_ack), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_aes(input txn_t t, input int exp_lat);
    bit seen;
    int nrv, first_rv;
    seen = 1'b0; nrv = 0; first_rv = -1;
    a_req = 1'b1; a_we = t.we; a_base = t.addr;
    for (int i = 0; i < BURST; i++) aes_wbuf[i] = t.wd[i];
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      if (a_rvalid) begin
        if (nrv < BURST) chk("aes_rdata", 64'(a_rdata), 64'(t.rd[nrv]));
        if (first_rv < 0) first_rv = k;
        nrv++;
      end
      if (a_done) begin
        seen = 1'b1;
        chk("aes_latency", 64'(k), 64'(exp_lat));
        chk("aes_rvalid_count", 64'(nrv), t.we ? 64'd0 : 64'(BURST));
        if (!t.we) chk("aes_first_rvalid", 64'(first_rv), 64'(exp_lat - (BURST - 1)));
        chk("aes_busy_at_done", 64'(busy), 64'd0);
      end
    end
    if (!seen) chk("aes_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    a_req = 1'b0;
    @(negedge clk);
    chk("aes_done_pulse", 64'(a_done), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_one(input txn_t t, input int exp_lat);
    if (t.aes) run_aes(t, exp_lat);
    else       run_host(t, exp_lat, 1'b0);
  endtask

  // f is granted first; s is raised d cycles after f (d=0: same cycle).
  task automatic run_pair(input txn_t f, input txn_t s, input int d);
    txn_t ff, ss;
    int lf, ls;
    ff = f; ss = s;
    model_apply(ff);
    model_apply(ss);
    lf = lat_of(ff);
    ls = lf + 1 + lat_of(ss) - d;
    fork
      run_one(ff, lf);
      begin
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1;
        end
        run_one(ss, ls);
      end
    join
    check_acc();
  endtask

  task automatic gap(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t, th, ta, h2;
    int   mode, d;
    bit   b;
    rst = 1'b1;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    a_req = 1'b0; a_we = 1'b0; a_base = '0;
    for (int i = 0; i < BURST; i++) aes_wbuf[i] = '0;

    pl_en = 1'b1;
    for (int i = 0; i < 128; i++) begin
      pl_addr = ADDR_W'(i);
      pl_data = (i >= 16 && i < 20) ? 32'hA0A0_0000 + 32'(i - 16) : $urandom;
      ref_mem[i] = pl_data;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
    check_zero();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Host write then read of address 5.
    t = '0; t.we = 1'b1; t.addr = 7'h05; t.wd[0] = 32'hDEADBEEF;
    model_apply(t); run_host(t, 2, 1'b0); check_acc();
    t = '0; t.addr = 7'h05;
    model_apply(t); run_host(t, 3, 1'b0); check_acc();
    chk("tp_host_read5", 64'(h_rdata), 64'hDEADBEEF);

    // AES read burst of the preloaded block at 0x10.
    t = '0; t.aes = 1'b1; t.addr = 7'h10;
    model_apply(t); run_aes(t, BURST + 2); check_acc();

    // AES write burst wrapping past 0x7F, then host read of 0x00.
    t = '0; t.aes = 1'b1; t.we = 1'b1; t.addr = 7'h7E;
    for (int i = 0; i < BURST; i++) t.wd[i] = 32'h100 + 32'(i);
    model_apply(t); run_aes(t, BURST + 1); check_acc();
    t = '0; t.addr = 7'h00;
    model_apply(t); run_host(t, 3, 1'b0); check_acc();
    chk("tp_wrap_read0", 64'(h_rdata), 64'h102);

    // Reset in cycle 2 of an AES read burst.
    a_req = 1'b1; a_we = 1'b0; a_base = ADDR_W'($urandom_range(0, 127));
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_zero();
    @(posedge clk); #1;
    a_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_no_aes_out", 64'({a_rvalid, a_done}), 64'd0);
    end
    @(posedge clk); #1;
    obs_q.delete(); exp_q.delete();
    exp_last_aes = 1'b1;
    exp_hrdata = '0;

    // Simultaneous requests after reset: host first, AES right after h_ack.
    th = rand_txn(1'b0); ta = rand_txn(1'b1);
    run_pair(th, ta, 0);

    // Both held: host, AES, host.
    th = rand_txn(1'b0); ta = rand_txn(1'b1); h2 = rand_txn(1'b0);
    model_apply(th); model_apply(ta); model_apply(h2);
    fork
      begin
        run_host(th, lat_of(th), 1'b1);
        run_host(h2, lat_of(ta) + 1 + lat_of(h2), 1'b0);
      end
      run_aes(ta, lat_of(th) + 1 + lat_of(ta));
    join
    check_acc();

    // Host raised in cycle 2 of an AES read burst.
    ta = '0; ta.aes = 1'b1; ta.addr = 7'h10;
    th = rand_txn(1'b0);
    run_pair(ta, th, 2);

    // Randomized mix of single, simultaneous and staggered transactions.
    for (int it = 0; it < 60; it++) begin
      mode = $urandom_range(0, 2);
      b = 1'($urandom_range(0, 1));
      case (mode)
        0: begin
          t = rand_txn(b);
          model_apply(t);
          run_one(t, lat_of(t));
          check_acc();
        end
        1: begin
          th = rand_txn(1'b0); ta = rand_txn(1'b1);
          if (exp_last_aes) run_pair(th, ta, 0);
          else              run_pair(ta, th, 0);
        end
        default: begin
          t = rand_txn(b); th = rand_txn(!b);
          d = $urandom_range(1, lat_of(t));
          run_pair(t, th, d);
        end
      endcase
      gap($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
